// File: rtl/chip8_alu_pkg.sv
// Shared opcode values, opcode enum and pipeline state enum for the CHIP-8 ALU.
package chip8_alu_pkg;

  localparam logic [3:0] OP_LD  = 4'h0;
  localparam logic [3:0] OP_OR  = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_XOR = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_SHR = 4'h6;
  localparam logic [3:0] OP_RSB = 4'h7;
  localparam logic [3:0] OP_SHL = 4'hE;
  localparam logic [3:0] OP_BCD = 4'hF;

  typedef enum logic [3:0] {
    ALU_LD  = OP_LD,
    ALU_OR  = OP_OR,
    ALU_AND = OP_AND,
    ALU_XOR = OP_XOR,
    ALU_ADD = OP_ADD,
    ALU_SUB = OP_SUB,
    ALU_SHR = OP_SHR,
    ALU_RSB = OP_RSB,
    ALU_SHL = OP_SHL,
    ALU_BCD = OP_BCD
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_t;

endpackage

// File: rtl/chip8_bcd_iter.sv
// Iterative double-dabble: one bit of a per cycle, MSB first, WIDTH cycles total.
// done is high during the cycle whose edge completes the last iteration; bcd is the value that edge produces.
module chip8_bcd_iter #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      a,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]    shreg;
  logic [4*DIGITS-1:0] acc;
  logic [4*DIGITS-1:0] adj;
  logic [CW-1:0]       cnt;

  always_comb begin
    adj = acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
  end

  assign bcd  = {adj[4*DIGITS-2:0], shreg[WIDTH-1]};
  assign done = busy && (cnt == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      acc   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      shreg <= a;
      acc   <= '0;
      cnt   <= CW'(WIDTH);
      busy  <= 1'b1;
    end else if (busy) begin
      shreg <= {shreg[WIDTH-2:0], 1'b0};
      acc   <= bcd;
      cnt   <= cnt - CW'(1);
      busy  <= !done;
    end
  end

endmodule

// File: rtl/chip8_alu_pipe.sv
// Registered CHIP-8 8xyN ALU with valid/ready handshakes and a multi-cycle BCD op (Fx33).
// Build option: CHIP8_QUIRK_VF_RESET_EN makes OR/AND/XOR write VF=0.
module chip8_alu_pipe
  import chip8_alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3,
  parameter int OPW    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPW-1:0]      in_op,
  input  logic [WIDTH-1:0]    in_a,
  input  logic [WIDTH-1:0]    in_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_result,
  output logic                out_vf,
  output logic                out_vf_wr,
  output logic [4*DIGITS-1:0] out_bcd,
  output logic                out_illegal
);

  alu_state_t          state, state_n;
  logic                accept;
  logic                is_bcd;
  logic                bcd_busy, bcd_done;
  logic [4*DIGITS-1:0] bcd_val;

  logic [WIDTH-1:0] res_c;
  logic             vf_c, vf_wr_c, ill_c;
  logic [WIDTH:0]   sum_ab, dif_ab, dif_ba;

  assign out_valid = (state == DONE);
  assign in_ready  = (state != BUSY) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign is_bcd    = (in_op == OP_BCD);

  assign sum_ab = {1'b0, in_a} + {1'b0, in_b};
  assign dif_ab = {1'b0, in_a} - {1'b0, in_b};
  assign dif_ba = {1'b0, in_b} - {1'b0, in_a};

  // Borrow lands in the extra top bit, so VF (not-borrow) is its inverse.
  always_comb begin
    res_c   = '0;
    vf_c    = 1'b0;
    vf_wr_c = 1'b0;
    ill_c   = 1'b0;
    case (in_op)
      OP_LD:  res_c = in_b;
`ifdef CHIP8_QUIRK_VF_RESET_EN
      OP_OR:  begin res_c = in_a | in_b; vf_wr_c = 1'b1; end
      OP_AND: begin res_c = in_a & in_b; vf_wr_c = 1'b1; end
      OP_XOR: begin res_c = in_a ^ in_b; vf_wr_c = 1'b1; end
`else
      OP_OR:  res_c = in_a | in_b;
      OP_AND: res_c = in_a & in_b;
      OP_XOR: res_c = in_a ^ in_b;
`endif
      OP_ADD: begin res_c = sum_ab[WIDTH-1:0]; vf_c = sum_ab[WIDTH];  vf_wr_c = 1'b1; end
      OP_SUB: begin res_c = dif_ab[WIDTH-1:0]; vf_c = !dif_ab[WIDTH]; vf_wr_c = 1'b1; end
      OP_SHR: begin res_c = in_a >> 1;         vf_c = in_a[0];        vf_wr_c = 1'b1; end
      OP_RSB: begin res_c = dif_ba[WIDTH-1:0]; vf_c = !dif_ba[WIDTH]; vf_wr_c = 1'b1; end
      OP_SHL: begin res_c = in_a << 1;         vf_c = in_a[WIDTH-1];  vf_wr_c = 1'b1; end
      OP_BCD: res_c = in_a;
      default: ill_c = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: begin
        if (accept)                        state_n = is_bcd ? BUSY : DONE;
        else if (state == DONE && out_ready) state_n = IDLE;
      end
      BUSY: begin
        if (bcd_done)       state_n = DONE;
        else if (!bcd_busy) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_result  <= '0;
      out_vf      <= 1'b0;
      out_vf_wr   <= 1'b0;
      out_bcd     <= '0;
      out_illegal <= 1'b0;
    end else if (accept) begin
      out_result  <= res_c;
      out_vf      <= vf_c;
      out_vf_wr   <= vf_wr_c;
      out_bcd     <= '0;
      out_illegal <= ill_c;
    end else if (bcd_done) begin
      out_bcd     <= bcd_val;
    end
  end

  chip8_bcd_iter #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept && is_bcd),
    .a     (in_a),
    .busy  (bcd_busy),
    .done  (bcd_done),
    .bcd   (bcd_val)
  );

endmodule

// File: tb/tb_chip8_alu_pipe.sv
// Randomised + directed bench for chip8_alu_pipe against a behavioural transaction model.
module tb_chip8_alu_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  in_op;
  logic [7:0]  in_a, in_b, out_result;
  logic        out_vf, out_vf_wr, out_illegal;
  logic [11:0] out_bcd;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int res;
    int vf;
    int wr;
    int bcd;
    int ill;
  } exp_t;

  exp_t m_exp;
  bit   m_valid = 0;
  int   m_busy  = 0;
  bit   m_acc   = 0;

  chip8_alu_pipe #(.WIDTH(8), .DIGITS(3), .OPW(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_vf      (out_vf),
    .out_vf_wr   (out_vf_wr),
    .out_bcd     (out_bcd),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t model_op(input int op, input int a, input int b);
    exp_t e = '{default: 0};
    case (op)
      0:  e.res = b;
      1:  e.res = a | b;
      2:  e.res = a & b;
      3:  e.res = a ^ b;
      4:  begin e.res = (a + b) % 256;       e.vf = (a + b > 255); e.wr = 1; end
      5:  begin e.res = (a - b + 256) % 256; e.vf = (a >= b);      e.wr = 1; end
      6:  begin e.res = a / 2;               e.vf = a % 2;         e.wr = 1; end
      7:  begin e.res = (b - a + 256) % 256; e.vf = (b >= a);      e.wr = 1; end
      14: begin e.res = (a * 2) % 256;       e.vf = (a >= 128);    e.wr = 1; end
      15: begin e.res = a; e.bcd = (a / 100) * 256 + ((a / 10) % 10) * 16 + a % 10; end
      default: e.ill = 1;
    endcase
`ifdef CHIP8_QUIRK_VF_RESET_EN
    if (op >= 1 && op <= 3) e.wr = 1;
`endif
    return e;
  endfunction

  // Called at a negedge: check what the previous edge produced, drive the next request, advance model.
  task automatic step(input bit v, input int op, input int a, input int b, input bit rdy);
    bit m_ready;
    chk("out_valid", out_valid, m_valid);
    if (m_valid) begin
      chk("out_result",  out_result,  m_exp.res);
      chk("out_vf",      out_vf,      m_exp.vf);
      chk("out_vf_wr",   out_vf_wr,   m_exp.wr);
      chk("out_bcd",     out_bcd,     m_exp.bcd);
      chk("out_illegal", out_illegal, m_exp.ill);
    end
    in_valid  = v;
    in_op     = 4'(op);
    in_a      = 8'(a);
    in_b      = 8'(b);
    out_ready = rdy;
    #1;
    m_ready = (m_busy == 0) && (!m_valid || rdy);
    chk("in_ready", in_ready, m_ready);
    m_acc = v && m_ready;
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) m_valid = 1;
    end else begin
      if (m_valid && rdy) m_valid = 0;
      if (m_acc) begin
        m_exp = model_op(op, a, b);
        if (op == 15) begin m_busy = 8; m_valid = 0; end
        else m_valid = 1;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    bit cv;
    int cop, ca, cb;
    rst_n = 1'b0; in_valid = 0; in_op = 0; in_a = 0; in_b = 0; out_ready = 0;
    #1;
    chk("rst_out_valid",   out_valid,   0);
    chk("rst_out_result",  out_result,  0);
    chk("rst_out_vf",      out_vf,      0);
    chk("rst_out_vf_wr",   out_vf_wr,   0);
    chk("rst_out_bcd",     out_bcd,     0);
    chk("rst_out_illegal", out_illegal, 0);
    chk("rst_in_ready",    in_ready,    1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Arithmetic and flag corner cases
    step(1, 4, 8'hFF, 8'h01, 1);
    chk("add_ff_01_res", out_result, 8'h00);
    chk("add_ff_01_vf",  out_vf,     1);
    step(1, 4, 8'h10, 8'h20, 1);
    chk("add_10_20_res", out_result, 8'h30);
    step(1, 5, 8'h05, 8'h05, 1);
    step(1, 7, 8'h06, 8'h05, 1);
    chk("rsb_res", out_result, 8'hFF);
    step(1, 14, 8'h81, 0, 1);
    step(1, 6, 8'h03, 0, 1);
    step(1, 9, 8'h12, 8'h34, 1);
    chk("illegal_flag", out_illegal, 1);
    step(1, 1, 8'hF0, 8'h0F, 1);
    chk("or_res", out_result, 8'hFF);
    step(0, 0, 0, 0, 1);

    // BCD: 254 then 0; in_ready low for the whole conversion
    step(1, 15, 8'hFE, 0, 1);
    repeat (8) step(1, 15, 8'h00, 0, 1);
    chk("bcd_254", out_bcd, 12'h254);
    repeat (8) step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // Back-to-back then a 3-cycle stall
    step(1, 0, 8'h11, 8'h22, 1);
    step(1, 3, 8'h5A, 8'hFF, 1);
    step(1, 2, 8'hF3, 8'h3C, 1);
    step(1, 4, 8'h80, 8'h80, 1);
    repeat (3) step(1, 1, 8'h01, 8'h02, 0);
    step(1, 1, 8'h01, 8'h02, 1);
    step(0, 0, 0, 0, 1);

    // Reset in the middle of a BCD conversion
    step(1, 15, 8'h99, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready",  in_ready,  1);
    chk("midrst_out_bcd",   out_bcd,   0);
    m_valid = 0; m_busy = 0;
    @(negedge clk);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(1, 4, 8'h21, 8'h12, 1);
    chk("post_rst_add", out_result, 8'h33);
    step(0, 0, 0, 0, 1);

    // Random traffic; a request is held until it is accepted
    cv = 0; cop = 0; ca = 0; cb = 0;
    for (int i = 0; i < 600; i++) begin
      if (!cv || m_acc) begin
        cv  = ($urandom_range(0, 3) != 0);
        cop = $urandom_range(0, 15);
        ca  = $urandom_range(0, 255);
        cb  = $urandom_range(0, 255);
      end
      step(cv, cop, ca, cb, ($urandom_range(0, 3) != 0));
    end
    repeat (10) step(0, 0, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
